frame_write_arbiter: RTL and testbench
======================================

// Module: frame_write_arbiter
// PURPOSE
//  Shares the single frame_buffer write port between the fill, line and symbol drawers and sequences the buffer swap.
//  Replaces the OR-combined write bus: each drawer presents valid/addr/data and stalls on ready.
//  Grants are round-robin with bounded bursts. swap is issued only once all accepted writes have landed.
// PARAMETERS
//  HOR_ACTIVE_PIXELS  640  frame width
//  VER_ACTIVE_PIXELS  480  frame height
//  N_REQ              3    requester count (0=fill, 1=line, 2=symbol)
//  MAX_BURST          16   max consecutive grants to one requester while others wait (>=1)
//  ADDR_WIDTH  (local) $clog2(HOR_ACTIVE_PIXELS*VER_ACTIVE_PIXELS)
// PORTS
//  clk           in   1                  system clock
//  reset         in   1                  synchronous, active-high reset
//  req_valid     in   N_REQ              per-requester write request
//  req_addr      in   N_REQ*ADDR_WIDTH   packed addrs, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//  req_data      in   N_REQ              per-requester pixel value
//  req_ready     out  N_REQ              one-hot: write of requester i accepted this cycle
//  write_enable  out  1                  frame_buffer write strobe (registered)
//  write_addr    out  ADDR_WIDTH         frame_buffer write address (registered)
//  write_data    out  1                  frame_buffer write data (registered)
//  swap_req      in   1                  pulse: request back/front buffer swap
//  swap_pending  out  1                  swap requested, not yet issued
//  swap          out  1                  one-cycle pulse to frame_buffer.swap
// BEHAVIOUR
//  Reset: req_ready=0, write_enable=0, write_addr=0, write_data=0, swap=0, swap_pending=0, rr pointer=0, burst count=0.
//  Reset mid-burst or mid-swap-wait drops all state; the accepted-but-unwritten pixel is discarded.
//  Transfer: req_valid[i] & req_ready[i] in cycle t -> write_enable=1 with that addr/data in cycle t+1 (latency 1).
//  req_ready is combinational from req_valid and registered arbiter state; at most one bit set.
//  Requester must hold valid/addr/data stable until ready; a valid may not be withdrawn before acceptance.
//  FSM states: IDLE, GRANT, DRAIN, SWAP.
//   IDLE: no owner. If swap_pending -> DRAIN. Else if any valid: owner = first valid at/after rr pointer, accept same cycle, burst=1 -> GRANT.
//   GRANT: owner accepted each cycle it is valid. Owner drops valid, or burst==MAX_BURST while another requester is valid,
//     -> rr pointer = owner+1 (mod N_REQ), burst=0, IDLE; the next owner is picked in that IDLE cycle (one bubble per handoff).
//     burst saturates at MAX_BURST if owner is the only valid requester (continues uninterrupted).
//     swap_pending in GRANT ends the burst at the next owner-not-valid or MAX_BURST boundary, as above.
//   DRAIN: no grants; wait one cycle for the last registered write to issue -> SWAP.
//   SWAP: swap=1 for exactly one cycle, swap_pending cleared -> IDLE.
//  swap_req: sets swap_pending next cycle; swap_req while already pending is absorbed (one swap only).
//  swap_req in the cycle swap is high sets pending again (a second swap follows).
//  Simultaneous swap_req and first request in IDLE: the request is granted; the swap waits for that burst to end.
//  N_REQ=1: rotation degenerates; MAX_BURST still forces an IDLE bubble only if swap_pending.
// CONFIGURATION
//  FRAME_WRITE_ARB_BOUNDS_CHECK_EN:
//   defined: an accepted request with addr >= HOR_ACTIVE_PIXELS*VER_ACTIVE_PIXELS is still acked (req_ready=1),
//     but write_enable stays 0 for it; extra output oob_error (1 bit) is sticky and cleared only by reset.
//   undefined: no check, no oob_error port; every accepted request produces a write.
// STRUCTURE
//  graphics_pkg: ADDR_WIDTH/X_WIDTH/Y_WIDTH derivation, requester index constants (REQ_FILL=0, REQ_LINE=1, REQ_SYMBOL=2),
//   FSM state encoding.
//  Sub-module rr_select: combinational round-robin pick (valid vector + pointer -> one-hot + index, any flag).
//  Top holds FSM, burst counter, output register stage, swap logic.
// TESTING
//  Single requester: line valid 5 cycles, addrs 10..14 -> ready 5 consecutive cycles, writes 10..14 on cycles t+1..t+5.
//  Contention, MAX_BURST=4: all three valid continuously -> grant sequence 0x4,bubble,1x4,bubble,2x4,bubble,0x4; no loss, no dup.
//  Stall hold: symbol valid but owner is fill -> symbol addr/data unchanged until ready; its write appears exactly once.
//  Swap during burst: swap_req at fill burst beat 2 -> burst ends at MAX_BURST, last write issues, swap one cycle later;
//   no write_enable in the swap cycle; swap_pending 1 from req+1 to swap cycle.
//  Double swap_req while pending -> single swap pulse; swap_req coincident with swap -> second pulse after DRAIN.
//  Bounds (macro on): addr 307200 accepted -> ready=1, write_enable=0, oob_error=1 until reset; reset mid-burst -> all outputs 0 next cycle.

Source files
------------

// File: rtl/graphics_pkg.sv
// Shared graphics definitions for the frame-buffer write path.
//   - frame geometry widths (default 640x480) and an address-width helper
//   - requester index constants for the three drawers
//   - write-arbiter FSM state encoding
package graphics_pkg;

  localparam int HOR_ACTIVE_PIXELS_DEF = 640;
  localparam int VER_ACTIVE_PIXELS_DEF = 480;

  function automatic int fb_addr_width(input int hor, input int ver);
    return $clog2(hor * ver);
  endfunction

  localparam int FB_ADDR_WIDTH = $clog2(HOR_ACTIVE_PIXELS_DEF * VER_ACTIVE_PIXELS_DEF);
  localparam int FB_X_WIDTH    = $clog2(HOR_ACTIVE_PIXELS_DEF);
  localparam int FB_Y_WIDTH    = $clog2(VER_ACTIVE_PIXELS_DEF);

  localparam int REQ_FILL   = 0;
  localparam int REQ_LINE   = 1;
  localparam int REQ_SYMBOL = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DRAIN = 2'd2,
    SWAP  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/frame_write_arbiter_rr_select.sv
// rr_select: combinational round-robin pick.
//   valid_i : request vector
//   ptr_i   : highest-priority index this cycle
//   grant_o : one-hot of the first valid at/after ptr_i (wrapping)
//   idx_o   : index of that requester
//   any_o   : at least one request valid
module rr_select #(
  parameter  int N_REQ = 3,
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] valid_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  always_comb begin
    int cand;
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    cand    = 0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = (int'(ptr_i) + k) % N_REQ;
      if (!any_o && valid_i[cand]) begin
        any_o         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/frame_write_arbiter.sv
// frame_write_arbiter: shares the single frame_buffer write port between the
// fill, line and symbol drawers and sequences the back/front buffer swap.
//
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   req_valid       per-requester write request
//   req_addr        packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_data        per-requester pixel value
//   req_ready       one-hot accept (combinational)
//   write_enable    registered frame_buffer write strobe
//   write_addr      registered frame_buffer write address
//   write_data      registered frame_buffer write data
//   swap_req        pulse requesting a buffer swap
//   swap_pending    swap requested but not yet issued
//   swap            one-cycle pulse to frame_buffer.swap
//   oob_error       (FRAME_WRITE_ARB_BOUNDS_CHECK_EN only) sticky out-of-frame flag
//
// Build option FRAME_WRITE_ARB_BOUNDS_CHECK_EN: accepted writes addressed past
// the frame are acked but suppressed and latch oob_error until reset.
module frame_write_arbiter
  import graphics_pkg::*;
#(
  parameter  int HOR_ACTIVE_PIXELS = 640,
  parameter  int VER_ACTIVE_PIXELS = 480,
  parameter  int N_REQ             = 3,
  parameter  int MAX_BURST         = 16,
  localparam int ADDR_WIDTH        = fb_addr_width(HOR_ACTIVE_PIXELS, VER_ACTIVE_PIXELS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [N_REQ-1:0]            req_data,
  output logic [N_REQ-1:0]            req_ready,
  output logic                        write_enable,
  output logic [ADDR_WIDTH-1:0]       write_addr,
  output logic                        write_data,
  input  logic                        swap_req,
  output logic                        swap_pending,
`ifdef FRAME_WRITE_ARB_BOUNDS_CHECK_EN
  output logic                        swap,
  output logic                        oob_error
`else
  output logic                        swap
`endif
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int BW    = $clog2(MAX_BURST + 1);

  arb_state_e          state_q;
  logic [IDX_W-1:0]    owner_q, rr_q;
  logic [BW-1:0]       burst_q;
  logic                pending_q, swap_q;
  logic                we_q, we_d;
  logic [ADDR_WIDTH-1:0] wa_q, wa_d;
  logic                wd_q, wd_d;

  logic [N_REQ-1:0]    sel_onehot, owner_mask;
  logic [IDX_W-1:0]    sel_idx, acc_idx, next_ptr;
  logic                sel_any, acc, in_bounds;
  logic                owner_valid, others_valid, burst_full, grant_end;

  rr_select #(.N_REQ(N_REQ)) u_rr_select (
    .valid_i (req_valid),
    .ptr_i   (rr_q),
    .grant_o (sel_onehot),
    .idx_o   (sel_idx),
    .any_o   (sel_any)
  );

  assign owner_mask   = N_REQ'(1) << owner_q;
  assign owner_valid  = |(req_valid & owner_mask);
  assign others_valid = |(req_valid & ~owner_mask);
  assign burst_full   = (burst_q == BW'(MAX_BURST));
  // A full burst only yields when someone else is waiting or a swap must go;
  // a lone owner keeps streaming with the counter saturated.
  assign grant_end    = !owner_valid || (burst_full && (others_valid || pending_q));
  assign next_ptr     = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

  always_comb begin
    req_ready = '0;
    acc       = 1'b0;
    acc_idx   = owner_q;
    case (state_q)
      IDLE: if (!pending_q && sel_any) begin
        req_ready = sel_onehot;
        acc       = 1'b1;
        acc_idx   = sel_idx;
      end
      GRANT: if (!grant_end) begin
        req_ready = owner_mask;
        acc       = 1'b1;
      end
      default: ;
    endcase
  end

  assign wa_d = acc ? req_addr[int'(acc_idx)*ADDR_WIDTH +: ADDR_WIDTH] : wa_q;
  assign wd_d = acc ? req_data[acc_idx] : wd_q;

`ifdef FRAME_WRITE_ARB_BOUNDS_CHECK_EN
  localparam logic [ADDR_WIDTH:0] PIX_LIMIT =
    (ADDR_WIDTH+1)'(HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS);
  logic oob_q;
  assign in_bounds = ({1'b0, wa_d} < PIX_LIMIT);
  assign oob_error = oob_q;
  always_ff @(posedge clk) begin
    if (reset) oob_q <= 1'b0;
    else if (acc && !in_bounds) oob_q <= 1'b1;
  end
`else
  assign in_bounds = 1'b1;
`endif

  assign we_d = acc && in_bounds;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      rr_q      <= '0;
      burst_q   <= '0;
      pending_q <= 1'b0;
      swap_q    <= 1'b0;
      we_q      <= 1'b0;
      wa_q      <= '0;
      wd_q      <= 1'b0;
    end else begin
      we_q   <= we_d;
      wa_q   <= wa_d;
      wd_q   <= wd_d;
      swap_q <= (state_q == DRAIN);
      // A request in the swap cycle re-arms pending for a second swap.
      if (swap_req)               pending_q <= 1'b1;
      else if (state_q == SWAP)   pending_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pending_q) begin
            state_q <= DRAIN;
          end else if (sel_any) begin
            owner_q <= sel_idx;
            burst_q <= BW'(1);
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (grant_end) begin
            rr_q    <= next_ptr;
            burst_q <= '0;
            state_q <= IDLE;
          end else if (!burst_full) begin
            burst_q <= burst_q + 1'b1;
          end
        end
        // One cycle for the last registered write to reach the buffer.
        DRAIN:   state_q <= SWAP;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign write_enable = we_q;
  assign write_addr   = wa_q;
  assign write_data   = wd_q;
  assign swap         = swap_q;
  assign swap_pending = pending_q;

endmodule

// File: tb/tb_frame_write_arbiter.sv
module tb_frame_write_arbiter;

  localparam int AW = $clog2(640 * 480);
  localparam int NR = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [NR-1:0] req_valid;
  logic [NR*AW-1:0] req_addr;
  logic [NR-1:0] req_data;
  logic [NR-1:0] req_ready;
  logic          write_enable;
  logic [AW-1:0] write_addr;
  logic          write_data;
  logic          swap_req, swap_pending, swap;
`ifdef FRAME_WRITE_ARB_BOUNDS_CHECK_EN
  logic          oob_error;
`endif

  int checks = 0;
  int passed = 0;

  frame_write_arbiter #(
    .HOR_ACTIVE_PIXELS(640), .VER_ACTIVE_PIXELS(480), .N_REQ(NR), .MAX_BURST(4)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready),
    .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
    .swap_req(swap_req), .swap_pending(swap_pending),
`ifdef FRAME_WRITE_ARB_BOUNDS_CHECK_EN
    .swap(swap), .oob_error(oob_error)
`else
    .swap(swap)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input int a, input logic d);
    req_addr[i*AW +: AW] = AW'(a);
    req_data[i] = d;
  endtask

  task automatic idle_inputs();
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    swap_req  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    next_cyc();
    next_cyc();
    reset = 1'b0;
  endtask

  initial begin
    int tab[19];
    int cnt[3];
    int prev, prev_addr, nwr, n200;
    logic prev_data;
    logic [8:0] rdy_m, pend_m, swap_m, we_m, sreq_m;
    int fa;

    do_reset();
    #1;
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_we", 32'(write_enable), 0);
    chk("rst_addr", 32'(write_addr), 0);
    chk("rst_data", 32'(write_data), 0);
    chk("rst_swap", 32'(swap), 0);
    chk("rst_pending", 32'(swap_pending), 0);
`ifdef FRAME_WRITE_ARB_BOUNDS_CHECK_EN
    chk("rst_oob", 32'(oob_error), 0);
`endif

    // Single requester: line writes 10..14
    do_reset();
    for (int k = 0; k < 5; k++) begin
      req_valid = 3'b010;
      set_req(1, 10 + k, k[0]);
      #1;
      chk("single_rdy", 32'(req_ready), 3'b010);
      chk("single_we", 32'(write_enable), (k > 0) ? 1 : 0);
      if (k > 0) begin
        chk("single_addr", 32'(write_addr), 10 + k - 1);
        chk("single_data", 32'(write_data), (k - 1) & 1);
      end
      next_cyc();
    end
    req_valid = '0;
    #1;
    chk("single_rdy_off", 32'(req_ready), 0);
    chk("single_we_last", 32'(write_enable), 1);
    chk("single_addr_last", 32'(write_addr), 14);
    next_cyc();
    chk("single_we_end", 32'(write_enable), 0);

    // Contention, MAX_BURST=4; 3 = bubble
    do_reset();
    tab = '{0,0,0,0,3,1,1,1,1,3,2,2,2,2,3,0,0,0,0};
    cnt = '{0,0,0};
    prev = 3; prev_addr = 0; prev_data = 1'b0; nwr = 0; n200 = 0;
    for (int c = 0; c < 19; c++) begin
      req_valid = 3'b111;
      for (int i = 0; i < 3; i++) set_req(i, i * 100 + cnt[i], cnt[i][0]);
      #1;
      chk("cont_rdy", 32'(req_ready), (tab[c] == 3) ? 0 : (1 << tab[c]));
      chk("cont_we", 32'(write_enable), (prev != 3) ? 1 : 0);
      if (prev != 3) begin
        chk("cont_addr", 32'(write_addr), prev_addr);
        chk("cont_data", 32'(write_data), 32'(prev_data));
      end
      if (write_enable === 1'b1) nwr++;
      if (write_enable === 1'b1 && write_addr === AW'(200)) n200++;
      if (tab[c] != 3) begin
        prev_addr = tab[c] * 100 + cnt[tab[c]];
        prev_data = cnt[tab[c]][0];
        cnt[tab[c]]++;
      end
      prev = tab[c];
      next_cyc();
    end
    req_valid = '0;
    #1;
    chk("cont_we_tail", 32'(write_enable), 1);
    chk("cont_addr_tail", 32'(write_addr), 7);
    if (write_enable === 1'b1) nwr++;
    next_cyc();
    chk("cont_we_idle", 32'(write_enable), 0);
    chk("cont_total_writes", 32'(nwr), 16);
    chk("stall_sym_once", 32'(n200), 1);

    // Swap during fill burst: swap_req at beat 2
    do_reset();
    rdy_m  = 9'b100001111;
    pend_m = 9'b011111100;
    swap_m = 9'b010000000;
    we_m   = 9'b000011110;
    fa = 500;
    for (int c = 0; c < 9; c++) begin
      req_valid = 3'b001;
      set_req(0, fa, 1'b0);
      swap_req = (c == 1);
      #1;
      chk("sw_rdy", 32'(req_ready), rdy_m[c] ? 1 : 0);
      chk("sw_pending", 32'(swap_pending), 32'(pend_m[c]));
      chk("sw_swap", 32'(swap), 32'(swap_m[c]));
      chk("sw_we", 32'(write_enable), 32'(we_m[c]));
      if (c == 4) chk("sw_last_addr", 32'(write_addr), 503);
      if (rdy_m[c]) fa++;
      next_cyc();
    end
    req_valid = '0;
    swap_req = 1'b0;
    #1;
    chk("sw_resume_we", 32'(write_enable), 1);
    chk("sw_resume_addr", 32'(write_addr), 504);

    // Double swap_req while pending, then swap_req coincident with swap
    do_reset();
    sreq_m = 9'b000001011;
    swap_m = 9'b001001000;
    pend_m = 9'b001111110;
    for (int c = 0; c < 9; c++) begin
      swap_req = sreq_m[c];
      #1;
      chk("dsw_swap", 32'(swap), 32'(swap_m[c]));
      chk("dsw_pending", 32'(swap_pending), 32'(pend_m[c]));
      chk("dsw_we", 32'(write_enable), 0);
      next_cyc();
    end
    swap_req = 1'b0;

    // Simultaneous swap_req and first request
    do_reset();
    swap_req = 1'b1;
    req_valid = 3'b010;
    set_req(1, 33, 1'b1);
    #1;
    chk("sim_rdy0", 32'(req_ready), 3'b010);
    next_cyc();
    swap_req = 1'b0;
    set_req(1, 34, 1'b0);
    #1;
    chk("sim_rdy1", 32'(req_ready), 3'b010);
    chk("sim_pending", 32'(swap_pending), 1);
    next_cyc();
    req_valid = '0;
    #1;
    chk("sim_rdy2", 32'(req_ready), 0);
    next_cyc();
    chk("sim_swap3", 32'(swap), 0);
    next_cyc();
    chk("sim_swap4", 32'(swap), 0);
    next_cyc();
    chk("sim_swap5", 32'(swap), 1);
    next_cyc();
    chk("sim_swap6", 32'(swap), 0);
    chk("sim_pend6", 32'(swap_pending), 0);

    // Reset mid-burst with a swap pending
    do_reset();
    req_valid = 3'b001;
    set_req(0, 7, 1'b1);
    next_cyc();
    set_req(0, 8, 1'b1);
    swap_req = 1'b1;
    next_cyc();
    swap_req = 1'b0;
    set_req(0, 9, 1'b1);
    reset = 1'b1;
    #1;
    chk("rmid_we_pre", 32'(write_enable), 1);
    chk("rmid_addr_pre", 32'(write_addr), 8);
    chk("rmid_pend_pre", 32'(swap_pending), 1);
    next_cyc();
    reset = 1'b0;
    req_valid = '0;
    #1;
    chk("rmid_we", 32'(write_enable), 0);
    chk("rmid_addr", 32'(write_addr), 0);
    chk("rmid_data", 32'(write_data), 0);
    chk("rmid_pend", 32'(swap_pending), 0);
    chk("rmid_swap", 32'(swap), 0);
    chk("rmid_rdy", 32'(req_ready), 0);
    next_cyc();
    chk("rmid_discard", 32'(write_enable), 0);

`ifdef FRAME_WRITE_ARB_BOUNDS_CHECK_EN
    do_reset();
    req_valid = 3'b100;
    set_req(2, 307200, 1'b1);
    #1;
    chk("oob_rdy", 32'(req_ready), 3'b100);
    next_cyc();
    req_valid = '0;
    #1;
    chk("oob_we", 32'(write_enable), 0);
    chk("oob_flag", 32'(oob_error), 1);
    next_cyc();
    next_cyc();
    req_valid = 3'b100;
    set_req(2, 5, 1'b1);
    #1;
    chk("oob_sticky", 32'(oob_error), 1);
    next_cyc();
    req_valid = '0;
    #1;
    chk("oob_inb_we", 32'(write_enable), 1);
    chk("oob_inb_addr", 32'(write_addr), 5);
    do_reset();
    #1;
    chk("oob_cleared", 32'(oob_error), 0);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
